// File: rtl/uart_io_buffer_pkg.sv
// Shared constants and helpers for the UART byte-buffering stage.
package uart_io_buffer_pkg;

  localparam int unsigned UART_FIFO_DEPTH_LOG2 = 3;
  localparam int unsigned UART_WIDTH           = 8;
  localparam int unsigned UART_DROP_W          = 8;

  // Memory-mapped UART address map seen by the datapath's control decode.
  localparam logic [31:0] UART_TX_DATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] UART_RX_DATA_ADDR = 32'h1000_0004;
  localparam logic [31:0] UART_STATUS_ADDR  = 32'h1000_0008;

  // Status word layout as read back by software from UART_STATUS_ADDR.
  typedef struct packed {
    logic [UART_DROP_W-1:0] rx_drop_count;
    logic                   rx_overflow;
    logic                   data_out_valid;
    logic                   data_in_ready;
  } uart_status_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [UART_DROP_W-1:0] sat_inc(input logic [UART_DROP_W-1:0] v);
    return (v == {UART_DROP_W{1'b1}}) ? v : v + UART_DROP_W'(1);
  endfunction

endpackage

// File: rtl/uart_io_buffer_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy count.
module sync_fifo_fwft #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned WIDTH      = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;
  logic             mem_we;

  // Full/empty come only from the registered count.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Head entry falls through to the output straight from storage.
  assign dout = mem_q[rd_ptr_q];

  // Accept/advance decisions; flush wins over any push or pop.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    mem_we   = push_ok && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; intentionally not reset, contents are qualified by count.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_io_buffer.sv
// Byte buffering between the CPU's memory-mapped UART port and the serial TX/RX.
module uart_io_buffer
  import uart_io_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
  parameter int unsigned WIDTH      = UART_WIDTH
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   Flush,
  input  logic [WIDTH-1:0]       DataIn,
  input  logic                   DataInValid,
  output logic                   DataInReady,
  output logic [WIDTH-1:0]       DataOut,
  output logic                   DataOutValid,
  input  logic                   DataOutReady,
  output logic [WIDTH-1:0]       tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [WIDTH-1:0]       rx_data,
  input  logic                   rx_valid,
  output logic                   rx_overflow,
  output logic [UART_DROP_W-1:0] rx_drop_count
);

  logic                   tx_full, tx_empty;
  logic                   rx_full, rx_empty;
  logic                   tx_pop;
  logic                   rx_pop_ok;
  logic                   overflow_ev;
  logic                   rx_overflow_q, rx_overflow_d;
  logic [UART_DROP_W-1:0] drop_count_q, drop_count_d;

  // Handshake outputs; TX side is held off while reset is asserted.
  assign DataInReady  = reset && !tx_full;
  assign tx_valid     = reset && !tx_empty;
  assign DataOutValid = !rx_empty;
  assign tx_pop       = tx_valid && tx_ready;

  // CPU stores in, serial transmitter out.
  sync_fifo_fwft #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_tx_fifo (
    .CLK   (CLK),
    .reset (reset),
    .flush (Flush),
    .push  (DataInValid),
    .pop   (tx_pop),
    .din   (DataIn),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Serial receiver in, CPU loads out.
  sync_fifo_fwft #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_rx_fifo (
    .CLK   (CLK),
    .reset (reset),
    .flush (Flush),
    .push  (rx_valid),
    .pop   (DataOutReady),
    .din   (rx_data),
    .dout  (DataOut),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // A received byte is counted as dropped only if no slot frees up this cycle.
  always_comb begin
    rx_pop_ok     = DataOutReady && !rx_empty;
    overflow_ev   = rx_valid && rx_full && !rx_pop_ok;
    rx_overflow_d = rx_overflow_q;
    drop_count_d  = drop_count_q;
    if (Flush) begin
      rx_overflow_d = 1'b0;
      drop_count_d  = '0;
    end else if (overflow_ev) begin
      rx_overflow_d = 1'b1;
      drop_count_d  = sat_inc(drop_count_q);
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      rx_overflow_q <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      rx_overflow_q <= rx_overflow_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign rx_overflow   = rx_overflow_q;
  assign rx_drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_io_buffer.sv
// Self-checking bench for uart_io_buffer against a queue-based reference model.
module tb_uart_io_buffer;

  localparam int DEPTH = 8;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       Flush = 1'b0;
  logic [7:0] DataIn = 8'h00;
  logic       DataInValid = 1'b0;
  logic       DataInReady;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_overflow;
  logic [7:0] rx_drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned tx_q[$];
  byte unsigned rx_q[$];
  bit           m_ovf;
  int           m_drop;

  uart_io_buffer dut (
    .CLK           (CLK),
    .reset         (reset),
    .Flush         (Flush),
    .DataIn        (DataIn),
    .DataInValid   (DataInValid),
    .DataInReady   (DataInReady),
    .DataOut       (DataOut),
    .DataOutValid  (DataOutValid),
    .DataOutReady  (DataOutReady),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_overflow   (rx_overflow),
    .rx_drop_count (rx_drop_count)
  );

  always #5 CLK = ~CLK;

  // Reference behaviour for one clock edge, using the inputs currently driven.
  task automatic model_step();
    bit tx_push, tx_pop, rx_push, rx_pop;
    if (!reset) begin
      tx_q.delete(); rx_q.delete(); m_ovf = 0; m_drop = 0;
    end else if (Flush) begin
      tx_q.delete(); rx_q.delete(); m_ovf = 0; m_drop = 0;
    end else begin
      tx_push = DataInValid && (tx_q.size() < DEPTH);
      tx_pop  = tx_ready && (tx_q.size() > 0);
      rx_push = rx_valid && (rx_q.size() < DEPTH);
      rx_pop  = DataOutReady && (rx_q.size() > 0);
      if (rx_valid && rx_q.size() == DEPTH && !rx_pop) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
      if (tx_pop) void'(tx_q.pop_front());
      if (tx_push) tx_q.push_back(DataIn);
      if (rx_pop) void'(rx_q.pop_front());
      if (rx_push) rx_q.push_back(rx_data);
    end
  endtask

  // {DataInReady, tx_valid, DataOutValid, rx_overflow, rx_drop_count} per the model.
  function automatic logic [11:0] exp_status();
    return {reset && (tx_q.size() < DEPTH), reset && (tx_q.size() != 0),
            rx_q.size() != 0, m_ovf, 8'(m_drop)};
  endfunction

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    Flush = 0; DataInValid = 0; DataOutReady = 0; tx_ready = 0; rx_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({DataInReady, tx_valid, DataOutValid, rx_overflow, rx_drop_count} !== 12'h000) begin
        $display("FAIL reset_hold: got %h expected %h",
                 {DataInReady, tx_valid, DataOutValid, rx_overflow, rx_drop_count}, 12'h000);
        n_fail++;
      end
    end
    reset = 1;
    tick();
    n_checks++;
    if ({DataInReady, tx_valid, DataOutValid, rx_overflow, rx_drop_count} !== 12'h800) begin
      $display("FAIL reset_release: got %h expected %h",
               {DataInReady, tx_valid, DataOutValid, rx_overflow, rx_drop_count}, 12'h800);
      n_fail++;
    end
  endtask

  task automatic test_tx_fill_drain();
    idle_inputs();
    DataInValid = 1;
    for (int i = 1; i <= 9; i++) begin
      DataIn = 8'(i);
      tick();
      n_checks++;
      if ({DataInReady, tx_valid, DataOutValid, rx_overflow, rx_drop_count} !== exp_status()) begin
        $display("FAIL tx_fill_status[%0d]: got %h expected %h", i,
                 {DataInReady, tx_valid, DataOutValid, rx_overflow, rx_drop_count}, exp_status());
        n_fail++;
      end
    end
    n_checks++;
    if (DataInReady !== 1'b0) begin
      $display("FAIL tx_full_ready: got %b expected 0", DataInReady);
      n_fail++;
    end
    DataInValid = 0;
    tx_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        $display("FAIL tx_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h",
                 i, tx_valid, tx_data, 8'(i));
        n_fail++;
      end
      tick();
    end
    n_checks++;
    if (tx_valid !== 1'b0) begin
      $display("FAIL tx_drain_empty: got %b expected 0", tx_valid);
      n_fail++;
    end
    idle_inputs();
  endtask

  task automatic test_full_push_pop();
    idle_inputs();
    DataInValid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      DataIn = 8'($urandom_range(0, 255));
      tick();
    end
    DataIn = 8'hAA; tx_ready = 1;
    tick();
    DataInValid = 0; tx_ready = 0;
    n_checks++;
    if (DataInReady !== 1'b1 || tx_q.size() != 7) begin
      $display("FAIL full_push_pop_ready: got %b expected 1 (model count %0d)",
               DataInReady, tx_q.size());
      n_fail++;
    end
    tx_ready = 1;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== tx_q[0]) begin
        $display("FAIL full_push_pop_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h",
                 i, tx_valid, tx_data, tx_q[0]);
        n_fail++;
      end
      tick();
    end
    n_checks++;
    if (tx_valid !== 1'b0) begin
      $display("FAIL full_push_pop_empty: got %b expected 0 (0xAA must not be stored)", tx_valid);
      n_fail++;
    end
    idle_inputs();
  endtask

  task automatic test_rx_fwft();
    idle_inputs();
    rx_data = 8'h41; rx_valid = 1;
    tick();
    rx_valid = 0;
    n_checks++;
    if (DataOutValid !== 1'b1 || DataOut !== 8'h41) begin
      $display("FAIL rx_fwft: got valid=%b data=%h expected valid=1 data=41", DataOutValid, DataOut);
      n_fail++;
    end
    DataOutReady = 1;
    tick();
    DataOutReady = 0;
    n_checks++;
    if (DataOutValid !== 1'b0) begin
      $display("FAIL rx_pop: got %b expected 0", DataOutValid);
      n_fail++;
    end
  endtask

  task automatic test_rx_overflow_flush();
    byte unsigned first;
    idle_inputs();
    rx_valid = 1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      rx_data = 8'($urandom_range(0, 255));
      if (i == 0) first = rx_data;
      tick();
    end
    rx_valid = 0;
    n_checks++;
    if (rx_overflow !== 1'b1 || rx_drop_count !== 8'd3 || DataOut !== first || DataOutValid !== 1'b1) begin
      $display("FAIL rx_overflow: got ovf=%b cnt=%0d head=%h expected ovf=1 cnt=3 head=%h",
               rx_overflow, rx_drop_count, DataOut, first);
      n_fail++;
    end
    DataInValid = 1; DataIn = 8'h5A;
    tick();
    DataInValid = 0;
    Flush = 1;
    tick();
    Flush = 0;
    n_checks++;
    if ({DataInReady, tx_valid, DataOutValid, rx_overflow, rx_drop_count} !== 12'h800) begin
      $display("FAIL flush_clear: got %h expected %h",
               {DataInReady, tx_valid, DataOutValid, rx_overflow, rx_drop_count}, 12'h800);
      n_fail++;
    end
  endtask

  task automatic test_flush_priority_saturate();
    idle_inputs();
    DataInValid = 1;
    for (int i = 0; i < 4; i++) begin
      DataIn = 8'($urandom_range(0, 255));
      tick();
    end
    DataIn = 8'hC3; Flush = 1;
    tick();
    DataInValid = 0; Flush = 0;
    n_checks++;
    if (tx_valid !== 1'b0 || DataInReady !== 1'b1) begin
      $display("FAIL flush_vs_push: got tx_valid=%b ready=%b expected 0 1", tx_valid, DataInReady);
      n_fail++;
    end
    tick();
    n_checks++;
    if (tx_valid !== 1'b0) begin
      $display("FAIL flush_push_discard: got %b expected 0", tx_valid);
      n_fail++;
    end
    rx_valid = 1;
    for (int i = 0; i < DEPTH + 300; i++) begin
      rx_data = 8'(i);
      tick();
    end
    rx_valid = 0;
    n_checks++;
    if (rx_drop_count !== 8'd255 || rx_overflow !== 1'b1) begin
      $display("FAIL drop_saturate: got cnt=%0d ovf=%b expected cnt=255 ovf=1", rx_drop_count, rx_overflow);
      n_fail++;
    end
    Flush = 1;
    tick();
    Flush = 0;
  endtask

  task automatic test_random_traffic();
    for (int c = 0; c < 1500; c++) begin
      reset        = ($urandom_range(0, 199) != 0);
      Flush        = ($urandom_range(0, 79) == 0);
      DataIn       = 8'($urandom_range(0, 255));
      DataInValid  = ($urandom_range(0, 2) != 0);
      tx_ready     = ($urandom_range(0, 1) != 0);
      rx_data      = 8'($urandom_range(0, 255));
      rx_valid     = ($urandom_range(0, 2) != 0);
      DataOutReady = ($urandom_range(0, 3) == 0);
      tick();
      n_checks++;
      if ({DataInReady, tx_valid, DataOutValid, rx_overflow, rx_drop_count} !== exp_status()) begin
        $display("FAIL random_status[%0d]: got %h expected %h", c,
                 {DataInReady, tx_valid, DataOutValid, rx_overflow, rx_drop_count}, exp_status());
        n_fail++;
      end
      if (tx_q.size() != 0 && reset) begin
        n_checks++;
        if (tx_data !== tx_q[0]) begin
          $display("FAIL random_tx_data[%0d]: got %h expected %h", c, tx_data, tx_q[0]);
          n_fail++;
        end
      end
      if (rx_q.size() != 0) begin
        n_checks++;
        if (DataOut !== rx_q[0]) begin
          $display("FAIL random_rx_data[%0d]: got %h expected %h", c, DataOut, rx_q[0]);
          n_fail++;
        end
      end
    end
    reset = 1;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_tx_fill_drain();
    test_full_push_pop();
    test_rx_fwft();
    test_rx_overflow_flush();
    test_flush_priority_saturate();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_io_buffer.md
Name: uart_io_buffer

Overview:
Byte-buffering stage between the CPU datapath's memory-mapped UART interface and the serial UART transmitter/receiver. Absorbs CPU store bursts to the UART TX data address into a TX FIFO and drains them to the transmitter under valid/ready. Collects received bytes into an RX FIFO and presents the head byte to the datapath's writeback mux with first-word-fall-through timing. Tracks RX overflow for software.

Parameters:
DEPTH_LOG2, 3, log2 of entries per FIFO (default 8 entries); TX and RX are identical.
WIDTH, 8, data width in bits.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset; sampled on rising CLK edge.
Flush  input  1  synchronous clear of both FIFOs and overflow state.
DataIn  input  WIDTH  byte from CPU store to the TX address.
DataInValid  input  1  CPU push into TX FIFO, one byte per cycle.
DataInReady  output  1  TX FIFO not full (CPU status read).
DataOut  output  WIDTH  RX FIFO head byte (FWFT).
DataOutValid  output  1  RX FIFO not empty (CPU status read).
DataOutReady  input  1  CPU pop from RX FIFO (load from RX address).
tx_data  output  WIDTH  byte to serial transmitter.
tx_valid  output  1  TX FIFO not empty.
tx_ready  input  1  transmitter accepts tx_data this cycle.
rx_data  input  WIDTH  byte from serial receiver.
rx_valid  input  1  one-cycle strobe: rx_data valid.
rx_overflow  output  1  sticky: a received byte was dropped.
rx_drop_count  output  8  saturating count of dropped RX bytes.

Behaviour:
- Reset (reset==0 at an edge): both FIFOs empty, pointers and counts 0, rx_overflow=0, rx_drop_count=0.
- While reset is low: DataInReady=0 and tx_valid=0. DataOutValid=0 follows from the cleared RX FIFO.
- After reset releases: DataInReady=1 and all other outputs 0.
- Each FIFO holds read pointer, write pointer (DEPTH_LOG2 bits, wrap modulo depth) and count (DEPTH_LOG2+1 bits).
  - full is count==2**DEPTH_LOG2.
  - empty is count==0.
  - full and empty are derived from registered count, never from same-cycle push/pop.
- Push is accepted iff push strobe && !full. Pop is accepted iff pop strobe && !empty.
- Rejected push: data is discarded and pointers are unchanged.
- Rejected pop: no effect.
- Simultaneous accepted push and pop: both pointers advance and count is unchanged.
- Push while full with simultaneous pop: pop accepted, push rejected. Count then decrements by 1.
- FWFT: the head entry drives the data output combinationally from storage at the read pointer.
  - A byte pushed into an empty FIFO at edge N is visible with valid=1 from edge N+1.
  - Minimum push-to-output latency is 1 cycle.
- TX FIFO:
  - push = DataInValid, pop = tx_valid && tx_ready.
  - DataInReady = !tx_full. tx_valid = !tx_empty. tx_data = head.
  - tx_data is stable while tx_valid && !tx_ready.
- RX FIFO:
  - push = rx_valid, pop = DataOutReady. DataOutValid = !rx_empty. DataOut = head.
  - Empty: DataOut holds the last storage value; it is don't-care and is not checked.
- RX overflow:
  - Condition: rx_valid while rx_full with no accepted pop that cycle.
  - Effect: byte dropped, rx_overflow set to 1, rx_drop_count incremented, saturating at 255.
- Flush has priority over push and pop in the same cycle.
  - It empties both FIFOs and clears rx_overflow and rx_drop_count.
  - Bytes presented that cycle are discarded.
- reset dominates Flush.
- Reset mid-transfer: tx_valid drops in the cycle reset is low. The transmitter must tolerate an abandoned offer.
- Storage arrays are not reset; only pointers and counts are.

Decomposition:
- Shared package: UART_FIFO_DEPTH_LOG2 default, WIDTH constant, and the TX/RX address map constants consumed by control decode.
- One sub-module, sync_fifo_fwft (parameters DEPTH_LOG2, WIDTH; ports CLK, reset, flush, push, pop, din, dout, full, empty).
- It is instantiated twice.
- Overflow/drop-count logic stays in uart_io_buffer.

Test Plan:
1. Reset low for 2 cycles, then release.
   - Required: DataInReady 0 during reset and 1 after release.
   - Required: tx_valid=0, DataOutValid=0, rx_overflow=0, rx_drop_count=0.
2. tx_ready=0; push bytes 0x01..0x09 on consecutive cycles.
   - Required: first 8 accepted, DataInReady=0 after 8th, 0x09 dropped.
   - Then tx_ready=1: tx_data drains 0x01..0x08 in order, one per cycle, and tx_valid falls after 0x08.
3. Full TX FIFO; push 0xAA with tx_ready=1 in the same cycle.
   - Required: pop accepted, 0xAA rejected, count becomes 7.
   - Next cycle: DataInReady=1.
4. Strobe rx_valid with 0x41 at edge N.
   - Required: DataOutValid=1 and DataOut=0x41 from edge N+1.
   - DataOutReady=1 for one cycle: DataOutValid=0 next.
5. Fill RX with 8 bytes, then send 3 more with no pop.
   - Required: rx_overflow=1, rx_drop_count=3, head is still the first byte.
   - Then Flush: both FIFOs empty, rx_overflow=0, rx_drop_count=0.
6. TX holds 4 bytes; DataInValid=1 and Flush=1 in the same cycle.
   - Required: TX empty next cycle and pushed byte discarded.
   - Drop 300 RX bytes with no pop: rx_drop_count saturates at 255.
